// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with a shared period counter and double-buffered rise/fall
// compare values that commit to every channel at once on the period boundary.
module pwm_bank #(
   parameter int WIDTH   = 13,
   parameter int NUM_CH  = 8,
   parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [WIDTH-1:0]    CYCLE,
   input  logic                SYNC,
   input  logic [NUM_CH-1:0]   ENABLE,
   input  logic                WR_EN,
   input  logic [CH_BITS-1:0]  WR_CH,
   input  logic [WIDTH-1:0]    WR_RISE,
   input  logic [WIDTH-1:0]    WR_FALL,
   output logic [WIDTH-1:0]    TIME_CNT,
   output logic                UPDATED,
   output logic [NUM_CH-1:0]   PWM_OUT
);

   localparam logic [CH_BITS:0] NUM_CH_W = (CH_BITS + 1)'(NUM_CH);

   logic [WIDTH-1:0]  t_q;
   logic [WIDTH-1:0]  cycle_last;
   logic              cycle_short;
   logic              boundary;
   logic              wr_valid;
   logic              pending_q;
   logic              commit;
   logic [NUM_CH-1:0] on;

   logic [WIDTH-1:0]  shadow_rise [NUM_CH];
   logic [WIDTH-1:0]  shadow_fall [NUM_CH];
   logic [WIDTH-1:0]  active_rise [NUM_CH];
   logic [WIDTH-1:0]  active_fall [NUM_CH];

   // cycle_last wraps when CYCLE is 0; cycle_short masks that case out.
   assign cycle_short = (CYCLE <= WIDTH'(1));
   assign cycle_last  = CYCLE - WIDTH'(1);
   assign boundary    = SYNC | cycle_short | (t_q >= cycle_last);
   assign wr_valid    = WR_EN & ({1'b0, WR_CH} < NUM_CH_W);
   assign commit      = boundary & pending_q;
   assign TIME_CNT    = t_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would make ordering between blocks matter.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         t_q <= '0;
      end else if (boundary) begin
         t_q <= '0;
      end else begin
         t_q <= t_q + WIDTH'(1);
      end
   end

   // NOTE: the register-file arrays are reset explicitly because a reset must
   // leave every channel silent with nothing waiting to commit.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow_rise[i] <= '0;
            shadow_fall[i] <= '0;
         end
      end else if (wr_valid) begin
         shadow_rise[WR_CH] <= WR_RISE;
         shadow_fall[WR_CH] <= WR_FALL;
      end
   end

   // The commit reads shadow before any same-cycle write lands, so a write on the
   // boundary waits for the next one; setting pending wins over clearing it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) begin
            active_rise[i] <= '0;
            active_fall[i] <= '0;
         end
         pending_q <= 1'b0;
         UPDATED   <= 1'b0;
      end else begin
         if (commit) begin
            for (int i = 0; i < NUM_CH; i++) begin
               active_rise[i] <= shadow_rise[i];
               active_fall[i] <= shadow_fall[i];
            end
         end
         if (wr_valid) begin
            pending_q <= 1'b1;
         end else if (commit) begin
            pending_q <= 1'b0;
         end
         UPDATED <= commit;
      end
   end

   // NOTE: the default assignment before the loop keeps this purely combinational;
   // R == F falls through and stays off without needing its own branch.
   always_comb begin
      on = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (active_rise[i] < active_fall[i]) begin
            on[i] = (active_rise[i] <= t_q) && (t_q < active_fall[i]);
         end else if (active_rise[i] > active_fall[i]) begin
            on[i] = (t_q < active_fall[i]) || (active_rise[i] <= t_q);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         PWM_OUT <= '0;
      end else begin
         PWM_OUT <= on & ENABLE;
      end
   end

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: stimulus queues cycle-tagged expectations,
// a negedge monitor compares whichever entries fall due in the current cycle.
module tb_pwm_bank;

   localparam int W   = 13;
   localparam int NCH = 6;
   localparam int CHB = 3;

   logic           CLK;
   logic           RST;
   logic [W-1:0]   CYCLE;
   logic           SYNC;
   logic [NCH-1:0] ENABLE;
   logic           WR_EN;
   logic [CHB-1:0] WR_CH;
   logic [W-1:0]   WR_RISE;
   logic [W-1:0]   WR_FALL;
   logic [W-1:0]   TIME_CNT;
   logic           UPDATED;
   logic [NCH-1:0] PWM_OUT;

   pwm_bank #(.WIDTH(W), .NUM_CH(NCH)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .CYCLE    (CYCLE),
      .SYNC     (SYNC),
      .ENABLE   (ENABLE),
      .WR_EN    (WR_EN),
      .WR_CH    (WR_CH),
      .WR_RISE  (WR_RISE),
      .WR_FALL  (WR_FALL),
      .TIME_CNT (TIME_CNT),
      .UPDATED  (UPDATED),
      .PWM_OUT  (PWM_OUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int             cyc;
      bit             ct;
      logic [W-1:0]   t;
      bit             cu;
      logic           upd;
      logic [NCH-1:0] mask;
      logic [NCH-1:0] pwm;
      string          nm;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input exp_t e, input bit late);
      bit ok;
      ok = !late;
      if (e.ct && (TIME_CNT !== e.t)) ok = 1'b0;
      if (e.cu && (UPDATED !== e.upd)) ok = 1'b0;
      if ((PWM_OUT & e.mask) !== (e.pwm & e.mask)) ok = 1'b0;
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s cyc=%0d: got TIME_CNT=%0d UPDATED=%0b PWM_OUT=%b, want t=%0d upd=%0b pwm=%b mask=%b late=%0b",
                    e.nm, e.cyc, TIME_CNT, UPDATED, PWM_OUT, e.t, e.upd, e.pwm, e.mask, late);
   endtask

   always @(negedge CLK) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc <= cyc) begin
            check(sb[i], sb[i].cyc < cyc);
            sb.delete(i);
         end
      end
   end

   task automatic push(input int n, input bit ct, input int t, input bit cu, input bit upd,
                       input logic [NCH-1:0] mask, input logic [NCH-1:0] pwm, input string nm);
      exp_t e;
      e.cyc = n; e.ct = ct; e.t = W'(t); e.cu = cu; e.upd = upd;
      e.mask = mask; e.pwm = pwm; e.nm = nm;
      sb.push_back(e);
   endtask

   // Counter runs 0..len-1 from n0; UPDATED is upd0 on the first cycle only.
   task automatic exp_time(input int n0, input bit upd0, input int len, input string nm);
      for (int k = 0; k < len; k++) push(n0 + k, 1'b1, k, 1'b1, (k == 0) ? upd0 : 1'b0, '0, '0, nm);
   endtask

   // pat[t] is the expected channel output one cycle after the counter shows t.
   task automatic exp_pwm(input int n0, input int ch, input logic [9:0] pat, input int len, input string nm);
      logic [NCH-1:0] m, v;
      for (int tt = 0; tt < len; tt++) begin
         m = '0; v = '0;
         m[ch] = 1'b1;
         v[ch] = pat[tt];
         push(n0 + 1 + tt, 1'b0, 0, 1'b0, 1'b0, m, v, nm);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic wr_at(input int n, input int ch, input int r, input int f);
      goto(n);
      WR_EN = 1'b1; WR_CH = CHB'(ch); WR_RISE = W'(r); WR_FALL = W'(f);
      tick();
      WR_EN = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, q, r, s, t1, t2, t3, u;
      RST = 1'b1; CYCLE = W'(10); SYNC = 1'b0; ENABLE = '1;
      WR_EN = 1'b0; WR_CH = '0; WR_RISE = '0; WR_FALL = '0;
      tick(); tick();
      push(cyc, 1'b1, 0, 1'b1, 1'b0, '1, '0, "reset_state");
      tick();
      RST = 1'b0;
      c0 = cyc;
      q  = c0 + 135;
      r  = q + 10;
      s  = r + 9;
      t1 = s + 5;
      t2 = t1 + 5;
      t3 = t2 + 5;
      u  = t3 + 5;

      // Idle: count 0..9 twice, outputs quiet.
      exp_time(c0, 1'b0, 10, "idle_p0");
      exp_time(c0 + 10, 1'b0, 10, "idle_p1");
      for (int k = 0; k < 20; k++) push(c0 + k, 1'b0, 0, 1'b0, 1'b0, '1, '0, "idle_pwm");
      // ch0 R=2 F=5 written mid-period.
      exp_time(c0 + 20, 1'b0, 10, "ch0_wait");
      exp_time(c0 + 30, 1'b1, 10, "ch0_commit");
      exp_pwm(c0 + 20, 0, 10'b0000000000, 10, "ch0_old");
      exp_pwm(c0 + 30, 0, 10'b0000011100, 10, "ch0_pulse");
      // ch1 wrapping pulse R=7 F=3; ch0 must be undisturbed.
      exp_time(c0 + 40, 1'b0, 10, "ch1_wait");
      exp_time(c0 + 50, 1'b1, 10, "ch1_commit");
      exp_pwm(c0 + 40, 0, 10'b0000011100, 10, "ch0_hold_a");
      exp_pwm(c0 + 50, 0, 10'b0000011100, 10, "ch0_hold_b");
      exp_pwm(c0 + 40, 1, 10'b0000000000, 10, "ch1_old");
      exp_pwm(c0 + 50, 1, 10'b1110000111, 10, "ch1_wrap");
      // ch2: last write wins, then R == F silences it.
      exp_time(c0 + 60, 1'b0, 10, "ch2_wait");
      exp_time(c0 + 70, 1'b1, 10, "ch2_commit");
      exp_time(c0 + 80, 1'b0, 10, "ch2_eq_wait");
      exp_time(c0 + 90, 1'b1, 10, "ch2_eq_commit");
      exp_pwm(c0 + 70, 2, 10'b0000111110, 10, "ch2_last_wins");
      exp_pwm(c0 + 80, 2, 10'b0000111110, 10, "ch2_keep");
      exp_pwm(c0 + 90, 2, 10'b0000000000, 10, "ch2_equal");
      // ch4 commits at the boundary; ch3 written on that boundary commits one period later.
      exp_time(c0 + 100, 1'b0, 10, "bwr_wait");
      exp_time(c0 + 110, 1'b1, 10, "bwr_first");
      exp_time(c0 + 120, 1'b1, 10, "bwr_second");
      exp_pwm(c0 + 110, 4, 10'b0000111000, 10, "ch4_pulse");
      exp_pwm(c0 + 110, 3, 10'b0000000000, 10, "ch3_deferred");
      exp_pwm(c0 + 120, 3, 10'b0000011111, 10, "ch3_pulse");
      // SYNC at t=4 restarts the period and commits ch5.
      exp_time(c0 + 130, 1'b0, 5, "sync_pre");
      exp_time(q, 1'b1, 10, "sync_restart");
      exp_pwm(c0 + 130, 5, 10'b0000000000, 5, "ch5_old");
      exp_pwm(q, 5, 10'b0000000110, 10, "ch5_pulse");
      // CYCLE lowered 10 -> 5 while t=8: wraps at once, then 0..4.
      exp_time(r, 1'b0, 9, "cyc_drop_pre");
      exp_time(s, 1'b0, 5, "cyc5_p0");
      exp_pwm(s, 0, 10'b0000011100, 5, "ch0_fall_past_cycle");
      exp_pwm(s, 1, 10'b0000000111, 5, "ch1_cycle5");
      exp_pwm(s, 4, 10'b0000011000, 5, "ch4_cycle5");
      exp_pwm(s, 3, 10'b0000011111, 5, "ch3_full");
      // ch3 R=6 F=8 beyond CYCLE stays low; ENABLE[0] low masks ch0.
      exp_time(t1, 1'b1, 5, "cyc5_commit");
      exp_pwm(t1, 3, 10'b0000000000, 5, "ch3_rise_past_cycle");
      exp_pwm(t1, 0, 10'b0000000000, 5, "ch0_disabled");
      exp_pwm(t1, 1, 10'b0000000111, 5, "ch1_enabled");
      // Out-of-range channel write must not set pending.
      exp_time(t2, 1'b0, 5, "badch_wait");
      exp_time(t3, 1'b0, 3, "badch_ignored");
      // Reset mid-period clears outputs and discards the pending ch0 write.
      push(t3 + 3, 1'b1, 0, 1'b1, 1'b0, '1, '0, "rst_mid_a");
      push(t3 + 4, 1'b1, 0, 1'b1, 1'b0, '1, '0, "rst_mid_b");
      exp_time(u, 1'b0, 5, "post_rst_p0");
      exp_time(u + 5, 1'b0, 5, "post_rst_p1");
      for (int k = 0; k < 11; k++) push(u + k, 1'b0, 0, 1'b0, 1'b0, '1, '0, "post_rst_pwm");

      wr_at(c0 + 23, 0, 2, 5);
      wr_at(c0 + 41, 1, 7, 3);
      wr_at(c0 + 62, 2, 4, 4);
      wr_at(c0 + 65, 2, 1, 6);
      wr_at(c0 + 80, 2, 4, 4);
      wr_at(c0 + 102, 4, 3, 6);
      wr_at(c0 + 109, 3, 0, 5);
      wr_at(c0 + 131, 5, 1, 3);
      goto(c0 + 134);
      SYNC = 1'b1;
      tick();
      SYNC = 1'b0;
      goto(r + 8);
      CYCLE = W'(5);
      wr_at(s + 1, 3, 6, 8);
      goto(t1);
      ENABLE[0] = 1'b0;
      goto(t2);
      ENABLE = '1;
      wr_at(t2 + 1, NCH, 1, 4);
      wr_at(t3 + 1, 0, 0, 2);
      goto(t3 + 3);
      RST = 1'b1;
      goto(u);
      RST = 1'b0;
      goto(u + 13);

      while (sb.size() > 0) begin
         n_checks++;
         $display("FAIL %s cyc=%0d: never compared, required a comparison", sb[0].nm, sb[0].cyc);
         sb.delete(0);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
